// File: rtl/rand_motion_integrator.sv
// Integrates a 4-bit signed random acceleration into a saturating velocity,
// then into a position bounded by reflecting walls; the CPU may reload position.
module rand_motion_integrator #(
    parameter int DIV      = 1000,
    parameter int VMAX     = 32,
    parameter int POS_MIN  = 0,
    parameter int POS_MAX  = 639,
    parameter int POS_INIT = 320
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] rand_in,
    input  logic        load_en,
    input  logic [31:0] load_pos,
    output logic [31:0] pos,
    output logic [31:0] vel,
    output logic        upd_valid,
    output logic        bounce
);
    typedef enum logic [1:0] {IDLE, ACCEL, MOVE} state_t;

    localparam logic [31:0]        DIV_LAST = 32'(DIV - 1);
    localparam logic signed [31:0] VHI      = 32'(VMAX);
    localparam logic signed [31:0] VLO      = 32'(-VMAX);
    localparam logic signed [31:0] PLO      = 32'(POS_MIN);
    localparam logic signed [31:0] PHI      = 32'(POS_MAX);
    localparam logic signed [32:0] PLO_W    = 33'(POS_MIN);
    localparam logic signed [32:0] PHI_W    = 33'(POS_MAX);
    localparam logic signed [31:0] PINIT    = 32'(POS_INIT);

    state_t             state_q, state_d;
    logic [31:0]        div_q, div_d;
    logic signed [31:0] acc_q, acc_d;
    logic signed [31:0] vel_q, vel_d;
    logic signed [31:0] pos_q, pos_d;
    logic               upd_q, upd_d;
    logic               bnc_q, bnc_d;

    logic signed [31:0] accel;
    logic signed [31:0] vsum;
    logic signed [32:0] psum;
    logic signed [31:0] ld;
    logic               unused_rand;

    assign unused_rand = ^rand_in[31:4];
    assign ld          = $signed(load_pos);
    // -8 is folded to 0 so the acceleration is symmetric about zero
    assign accel = (rand_in[3:0] == 4'b1000) ? 32'sd0 : $signed({{28{rand_in[3]}}, rand_in[3:0]});
    assign vsum  = vel_q + acc_q;
    assign psum  = $signed({pos_q[31], pos_q}) + $signed({vel_q[31], vel_q});

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        acc_d   = acc_q;
        vel_d   = vel_q;
        pos_d   = pos_q;
        upd_d   = 1'b0;
        bnc_d   = 1'b0;
        if (load_en) begin
            state_d = IDLE;
            div_d   = '0;
            vel_d   = '0;
            if (ld < PLO)      pos_d = PLO;
            else if (ld > PHI) pos_d = PHI;
            else               pos_d = ld;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        if (div_q == DIV_LAST) begin
                            div_d   = '0;
                            acc_d   = accel;
                            state_d = ACCEL;
                        end else begin
                            div_d = div_q + 32'd1;
                        end
                    end
                end
                ACCEL: begin
                    if (vsum > VHI)      vel_d = VHI;
                    else if (vsum < VLO) vel_d = VLO;
                    else                 vel_d = vsum;
                    state_d = MOVE;
                end
                MOVE: begin
                    // negation is safe: |vel| never exceeds VMAX
                    if (psum > PHI_W) begin
                        pos_d = PHI;
                        vel_d = -vel_q;
                        bnc_d = 1'b1;
                    end else if (psum < PLO_W) begin
                        pos_d = PLO;
                        vel_d = -vel_q;
                        bnc_d = 1'b1;
                    end else begin
                        pos_d = psum[31:0];
                    end
                    upd_d   = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            div_q   <= '0;
            acc_q   <= '0;
            vel_q   <= '0;
            pos_q   <= PINIT;
            upd_q   <= 1'b0;
            bnc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            acc_q   <= acc_d;
            vel_q   <= vel_d;
            pos_q   <= pos_d;
            upd_q   <= upd_d;
            bnc_q   <= bnc_d;
        end
    end

    assign pos       = pos_q;
    assign vel       = vel_q;
    assign upd_valid = upd_q;
    assign bounce    = bnc_q;
endmodule

// File: tb/tb_rand_motion_integrator.sv
// Directed bench for rand_motion_integrator: a cycle model built from
// "cycles since sample" bookkeeping is checked every cycle, plus literal pins.
module tb_rand_motion_integrator;
    localparam int DIV = 4, VMAX = 8, PMIN = 0, PMAX = 100, PINIT = 50;

    logic        clock, reset, enable, load_en;
    logic [31:0] rand_in, load_pos, pos, vel;
    logic        upd_valid, bounce;

    rand_motion_integrator #(.DIV(DIV), .VMAX(VMAX), .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_INIT(PINIT)) dut (
        .clock(clock), .reset(reset), .enable(enable), .rand_in(rand_in),
        .load_en(load_en), .load_pos(load_pos), .pos(pos), .vel(vel),
        .upd_valid(upd_valid), .bounce(bounce)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0, n_err = 0;
    // model: enabled cycles counted, then "since" = cycles elapsed after a sample
    int m_pos, m_vel, m_acc, m_cnt, since;
    int m_upd, m_bnc;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    function automatic int decode(input logic [31:0] r);
        int a;
        a = int'(r[3:0]);
        if (a >= 8) a = a - 16;
        if (a == -8) a = 0;
        return a;
    endfunction

    task automatic model_tick();
        longint p;
        m_upd = 0;
        m_bnc = 0;
        if (reset) begin
            m_pos = PINIT; m_vel = 0; m_acc = 0; m_cnt = 0; since = -1;
        end else if (load_en) begin
            m_pos = clampi(int'($signed(load_pos)), PMIN, PMAX); m_vel = 0; m_cnt = 0; since = -1;
        end else if (since == 0) begin
            m_vel = clampi(m_vel + m_acc, -VMAX, VMAX);
            since = 1;
        end else if (since == 1) begin
            p = longint'(m_pos) + longint'(m_vel);
            if (p > PMAX)      begin m_pos = PMAX; m_vel = -m_vel; m_bnc = 1; end
            else if (p < PMIN) begin m_pos = PMIN; m_vel = -m_vel; m_bnc = 1; end
            else               m_pos = int'(p);
            m_upd = 1;
            since = -1;
        end else if (enable) begin
            m_cnt++;
            if (m_cnt == DIV) begin
                m_cnt = 0;
                m_acc = decode(rand_in);
                since = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        model_tick();
        #1;
        chk("pos", longint'($signed(pos)), m_pos);
        chk("vel", longint'($signed(vel)), m_vel);
        chk("upd_valid", longint'(upd_valid), m_upd);
        chk("bounce", longint'(bounce), m_bnc);
    endtask

    task automatic wait_upd(input int maxc, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (upd_valid !== 1'b1 && n < maxc);
        if (upd_valid !== 1'b1) chk("upd_timeout", 0, 1);
    endtask

    task automatic expect_upd(input string nm, input int v, input int p, input int b);
        int n;
        wait_upd(20, n);
        chk({nm, "_period"}, n, DIV + 2);
        chk({nm, "_vel"}, longint'($signed(vel)), v);
        chk({nm, "_pos"}, longint'($signed(pos)), p);
        chk({nm, "_bounce"}, longint'(bounce), b);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; load_en = 1'b0; rand_in = '0; load_pos = '0;

        // 1: reset, then hold with enable low
        repeat (2) step();
        reset = 1'b0;
        repeat (20) step();
        chk("idle_pos", longint'($signed(pos)), 50);
        chk("idle_vel", longint'($signed(vel)), 0);

        // 2: constant +3 acceleration, saturating at 8
        enable = 1'b1; rand_in = 32'h0000_0003;
        expect_upd("u1", 3, 53, 0);
        expect_upd("u2", 6, 59, 0);
        expect_upd("u3", 8, 67, 0);
        expect_upd("u4", 8, 75, 0);

        // 3: -8 encoding decodes to zero acceleration
        reset = 1'b1; step(); reset = 1'b0;
        expect_upd("r1", 3, 53, 0);
        rand_in = 32'hFFFF_FFF8;
        expect_upd("neg8", 3, 56, 0);

        // 4: bounce off the upper wall
        load_en = 1'b1; load_pos = 32'd98; step(); load_en = 1'b0;
        chk("load_pos", longint'($signed(pos)), 98);
        chk("load_vel", longint'($signed(vel)), 0);
        rand_in = 32'd7;
        expect_upd("bnc", -7, 100, 1);
        rand_in = 32'd0;
        expect_upd("after_bnc", -7, 93, 0);

        // 5: load during ACCEL abandons the update and clamps to POS_MAX
        rand_in = 32'd2;
        repeat (DIV) step();
        load_en = 1'b1; load_pos = 32'd200; step(); load_en = 1'b0;
        chk("ldacc_pos", longint'($signed(pos)), 100);
        chk("ldacc_vel", longint'($signed(vel)), 0);
        chk("ldacc_upd", longint'(upd_valid), 0);
        expect_upd("ldacc_next", -2, 100, 1);

        // 6: reset during MOVE, then gated enable
        reset = 1'b1; step(); reset = 1'b0;
        rand_in = 32'd3;
        expect_upd("m1", 3, 53, 0);
        expect_upd("m2", 6, 59, 0);
        expect_upd("m3", 8, 67, 0);
        repeat (DIV + 1) step();
        chk("inmove_vel", longint'($signed(vel)), 8);
        chk("inmove_pos", longint'($signed(pos)), 67);
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_pos", longint'($signed(pos)), 50);
        chk("rst_vel", longint'($signed(vel)), 0);
        chk("rst_upd", longint'(upd_valid), 0);
        rand_in = 32'd1;
        for (int k = 0; k < DIV; k++) begin
            enable = 1'b0; step();
            enable = 1'b1; step();
        end
        enable = 1'b0; step();
        chk("gate_upd_early", longint'(upd_valid), 0);
        step();
        chk("gate_upd", longint'(upd_valid), 1);
        chk("gate_vel", longint'($signed(vel)), 1);
        chk("gate_pos", longint'($signed(pos)), 51);
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
